// File: rtl/sm4_mode_ctrl.sv
// sm4_mode_ctrl: valid/ready stream front-end for sm4_core (key expansion, block issue/capture,
// watchdog). ECB only by default; define SM4_CBC_EN to add CBC chaining with iv_in/iv_load/cbc_mode.
module sm4_mode_ctrl #(
    parameter int unsigned CORE_TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic [127:0] iv_in,
    input  logic         iv_load,
    input  logic         cbc_mode,
    input  logic         encdec_in,
    input  logic [127:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [127:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         busy,
    output logic         err,
    output logic         core_en_sm4,
    output logic         core_encdec,
    output logic         core_en_key_exps,
    output logic [127:0] core_key,
    output logic         core_key_valid,
    input  logic         core_key_exps_done,
    output logic [127:0] core_bdi,
    output logic         core_bdi_valid,
    input  logic [127:0] core_bdo,
    input  logic         core_bdo_valid
);

    // Stream handshake (s_* and m_*): a word moves on a rising edge where valid and ready are
    // both high; valid holds its payload stable until then, and ready never waits on valid.

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYEXP,
        S_READY,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [9:0] TMO_LIMIT = 10'(CORE_TIMEOUT);

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic         encdec_q, encdec_d;
    logic [127:0] blk_q, blk_d;
    logic [9:0]   tmo_q, tmo_d;
    logic         tmo_hit;
    logic         err_q, err_d;
    logic         busy_q, busy_d;
    logic         s_ready_q, s_ready_d;
    logic         m_valid_q, m_valid_d;
    logic [127:0] m_data_q, m_data_d;
    logic         en_sm4_q, en_sm4_d;
    logic         en_key_exps_q, en_key_exps_d;
    logic         key_valid_q, key_valid_d;
    logic [127:0] bdi_q, bdi_d;
    logic         bdi_valid_q, bdi_valid_d;

    logic [127:0] issue_bdi;
    logic [127:0] out_data;

`ifdef SM4_CBC_EN
    logic [127:0] chain_q, chain_d;
    logic [127:0] chain_next;
    logic         cbc_q, cbc_d;

    // Encrypt chains on the ciphertext it produced; decrypt chains on the ciphertext it consumed.
    always_comb begin
        issue_bdi  = (cbc_q && encdec_q) ? (blk_q ^ chain_q) : blk_q;
        out_data   = (cbc_q && !encdec_q) ? (core_bdo ^ chain_q) : core_bdo;
        chain_next = chain_q;
        if (cbc_q) begin
            chain_next = encdec_q ? core_bdo : blk_q;
        end
    end
`else
    logic unused_cbc_inputs;

    assign issue_bdi         = blk_q;
    assign out_data          = core_bdo;
    assign unused_cbc_inputs = ^{iv_in, iv_load, cbc_mode};
`endif

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        encdec_d      = encdec_q;
        blk_d         = blk_q;
        tmo_d         = tmo_q;
        err_d         = err_q;
        s_ready_d     = s_ready_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        en_sm4_d      = en_sm4_q;
        en_key_exps_d = en_key_exps_q;
        key_valid_d   = key_valid_q;
        bdi_d         = bdi_q;
        bdi_valid_d   = bdi_valid_q;
        tmo_hit       = (tmo_q == TMO_LIMIT);
`ifdef SM4_CBC_EN
        chain_d       = chain_q;
        cbc_d         = cbc_q;
        // The IV lands in the same edge a block is accepted, so that block sees the new IV.
        if ((state_q == S_IDLE || state_q == S_READY) && iv_load) begin
            chain_d = iv_in;
        end
`endif

        if ((state_q == S_IDLE || state_q == S_READY) && key_load) begin
            state_d       = S_KEYEXP;
            key_d         = key_in;
            encdec_d      = encdec_in;
            err_d         = 1'b0;
            s_ready_d     = 1'b0;
            en_sm4_d      = 1'b1;
            en_key_exps_d = 1'b1;
            key_valid_d   = 1'b1;
`ifdef SM4_CBC_EN
            cbc_d         = cbc_mode;
`endif
        end else begin
            case (state_q)
                S_KEYEXP: begin
                    if (core_key_exps_done) begin
                        state_d       = S_READY;
                        en_key_exps_d = 1'b0;
                        key_valid_d   = 1'b0;
                        s_ready_d     = 1'b1;
                    end else if (tmo_hit) begin
                        state_d       = S_IDLE;
                        err_d         = 1'b1;
                        en_sm4_d      = 1'b0;
                        en_key_exps_d = 1'b0;
                        key_valid_d   = 1'b0;
                    end else begin
                        tmo_d = tmo_q + 10'd1;
                    end
                end
                S_READY: begin
                    if (s_valid) begin
                        blk_d     = s_data;
                        s_ready_d = 1'b0;
                        state_d   = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    bdi_d       = issue_bdi;
                    bdi_valid_d = 1'b1;
                    state_d     = S_WAIT;
                end
                S_WAIT: begin
                    if (core_bdo_valid) begin
                        m_data_d    = out_data;
                        m_valid_d   = 1'b1;
                        bdi_valid_d = 1'b0;
                        state_d     = S_OUT;
`ifdef SM4_CBC_EN
                        chain_d     = chain_next;
`endif
                    end else if (tmo_hit) begin
                        state_d     = S_IDLE;
                        err_d       = 1'b1;
                        bdi_valid_d = 1'b0;
                        bdi_d       = '0;
                        en_sm4_d    = 1'b0;
`ifdef SM4_CBC_EN
                        chain_d     = '0;
`endif
                    end else begin
                        tmo_d = tmo_q + 10'd1;
                    end
                end
                S_OUT: begin
                    if (m_ready) begin
                        m_valid_d = 1'b0;
                        s_ready_d = 1'b1;
                        state_d   = S_READY;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Watchdog restarts on every state entry.
        if (state_d != state_q) begin
            tmo_d = '0;
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_READY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            key_q         <= '0;
            encdec_q      <= 1'b0;
            blk_q         <= '0;
            tmo_q         <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            s_ready_q     <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            en_sm4_q      <= 1'b0;
            en_key_exps_q <= 1'b0;
            key_valid_q   <= 1'b0;
            bdi_q         <= '0;
            bdi_valid_q   <= 1'b0;
`ifdef SM4_CBC_EN
            chain_q       <= '0;
            cbc_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            encdec_q      <= encdec_d;
            blk_q         <= blk_d;
            tmo_q         <= tmo_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            s_ready_q     <= s_ready_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            en_sm4_q      <= en_sm4_d;
            en_key_exps_q <= en_key_exps_d;
            key_valid_q   <= key_valid_d;
            bdi_q         <= bdi_d;
            bdi_valid_q   <= bdi_valid_d;
`ifdef SM4_CBC_EN
            chain_q       <= chain_d;
            cbc_q         <= cbc_d;
`endif
        end
    end

    // key_load wins over a same-cycle block, so ready drops combinationally.
    assign s_ready          = s_ready_q & ~key_load;
    assign m_data           = m_data_q;
    assign m_valid          = m_valid_q;
    assign busy             = busy_q;
    assign err              = err_q;
    assign core_en_sm4      = en_sm4_q;
    assign core_encdec      = encdec_q;
    assign core_en_key_exps = en_key_exps_q;
    assign core_key         = key_q;
    assign core_key_valid   = key_valid_q;
    assign core_bdi         = bdi_q;
    assign core_bdi_valid   = bdi_valid_q;

endmodule

// File: tb/tb_sm4_mode_ctrl.sv
// Testbench for sm4_mode_ctrl: behavioural sm4_core stand-in, vector table, scoreboard queue,
// and hand-written sequences for backpressure, priority, watchdog and reset.
module tb_sm4_mode_ctrl;

    localparam logic [127:0] K0 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] P0 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] C0 = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] P1 = 128'h693d9a535bad5bb1786f53d7253a7056;
    localparam int KEXP_LAT = 6;
    localparam int BLK_LAT  = 5;

    logic         clk, rst;
    logic [127:0] key_in, iv_in, s_data, m_data;
    logic         key_load, iv_load, cbc_mode, encdec_in, s_valid, s_ready, m_valid, m_ready;
    logic         busy, err;
    logic         core_en_sm4, core_encdec, core_en_key_exps, core_key_valid, core_key_exps_done;
    logic [127:0] core_key, core_bdi, core_bdo;
    logic         core_bdi_valid, core_bdo_valid;
    logic         core_hang;

    int n_checks = 0;
    int n_pass   = 0;
    logic [127:0] exp_q[$];

    sm4_mode_ctrl #(.CORE_TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst),
        .key_in(key_in), .key_load(key_load),
        .iv_in(iv_in), .iv_load(iv_load),
        .cbc_mode(cbc_mode), .encdec_in(encdec_in),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .err(err),
        .core_en_sm4(core_en_sm4), .core_encdec(core_encdec),
        .core_en_key_exps(core_en_key_exps), .core_key(core_key),
        .core_key_valid(core_key_valid), .core_key_exps_done(core_key_exps_done),
        .core_bdi(core_bdi), .core_bdi_valid(core_bdi_valid),
        .core_bdo(core_bdo), .core_bdo_valid(core_bdo_valid)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "simulation time limit");
    end

    // ---- sm4_core stand-in: known SM4 pairs for K0, an invertible toy cipher elsewhere ----
    function automatic logic [127:0] core_f(input logic enc, input logic [127:0] k,
                                            input logic [127:0] x);
        logic [127:0] t;
        if (k == K0 && enc && x == P0) return C0;
        if (k == K0 && !enc && x == C0) return P0;
        if (enc) begin
            t = x ^ k;
            return {t[120:0], t[127:121]};
        end
        t = {x[6:0], x[127:7]};
        return t ^ k;
    endfunction

    logic [3:0]   kx_cnt;
    logic [127:0] mdl_key;
    logic         mdl_enc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            kx_cnt             <= '0;
            core_key_exps_done <= 1'b0;
            mdl_key            <= '0;
            mdl_enc            <= 1'b0;
        end else begin
            core_key_exps_done <= 1'b0;
            if (!(core_en_key_exps && core_key_valid)) begin
                kx_cnt <= '0;
            end else if (kx_cnt != 4'(KEXP_LAT)) begin
                kx_cnt <= kx_cnt + 4'd1;
                if (kx_cnt == 4'(KEXP_LAT - 1)) begin
                    core_key_exps_done <= 1'b1;
                    mdl_key            <= core_key;
                    mdl_enc            <= core_encdec;
                end
            end
        end
    end

    logic         blk_busy, blk_hold;
    logic [3:0]   blk_cnt;
    logic [127:0] blk_m, last_bdi;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_busy       <= 1'b0;
            blk_hold       <= 1'b0;
            blk_cnt        <= '0;
            blk_m          <= '0;
            last_bdi       <= '0;
            core_bdo       <= '0;
            core_bdo_valid <= 1'b0;
        end else begin
            core_bdo_valid <= 1'b0;
            if (!core_bdi_valid) blk_hold <= 1'b0;
            if (blk_busy) begin
                if (blk_cnt == 4'(BLK_LAT - 1)) begin
                    core_bdo_valid <= 1'b1;
                    core_bdo       <= core_f(mdl_enc, mdl_key, blk_m);
                    blk_busy       <= 1'b0;
                    blk_hold       <= 1'b1;
                end else begin
                    blk_cnt <= blk_cnt + 4'd1;
                end
            end else if (core_bdi_valid && core_en_sm4 && !blk_hold && !core_hang) begin
                blk_busy <= 1'b1;
                blk_cnt  <= '0;
                blk_m    <= core_bdi;
                last_bdi <= core_bdi;
            end
        end
    end

    // ---- checking ----
    task automatic check(input string name, input logic [131:0] act, input logic [131:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, expv);
    endtask

    // Scoreboard: pop one expected block per output handshake.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %h, required no output", m_data);
            end else begin
                check("m_data", {4'h0, m_data}, {4'h0, exp_q.pop_front()});
            end
        end
    end

    // ---- driver tasks ----
    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            n_checks++;
            $display("FAIL %s: s_ready low after %0d cycles, required high", name, n);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 132'(exp_q.size()), 132'd0);
    endtask

    task automatic load_key(input logic enc, input logic cbc, input logic [127:0] k);
        @(posedge clk); #1;
        key_in    = k;
        encdec_in = enc;
        cbc_mode  = cbc;
        key_load  = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        @(negedge clk);
        check("keyexp_ctrl", {128'h0, core_en_key_exps, core_key_valid, core_en_sm4, core_encdec},
              {128'h0, 1'b1, 1'b1, 1'b1, enc});
        check("keyexp_key", {4'h0, core_key}, {4'h0, k});
        wait_ready("keyexp_done");
    endtask

    task automatic load_iv(input logic [127:0] v);
        @(posedge clk); #1;
        iv_in   = v;
        iv_load = 1'b1;
        @(posedge clk); #1;
        iv_load = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] d, input logic [127:0] e, input logic expect_out);
        wait_ready("send_ready");
        s_data  = d;
        s_valid = 1'b1;
        if (expect_out) exp_q.push_back(e);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_bdi_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!core_bdi_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, {131'h0, core_bdi_valid}, 132'd1);
    endtask

    typedef struct {
        logic         enc;
        logic [127:0] key;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t         vecs[6];
    logic [127:0] rk, rd, iv, x, y, prev;
    int           n, bad;

    initial begin
        rst = 1'b1; key_in = '0; key_load = 1'b0; iv_in = '0; iv_load = 1'b0;
        cbc_mode = 1'b0; encdec_in = 1'b0; s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
        core_hang = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {123'h0, s_ready, m_valid, busy, err, core_en_sm4, core_encdec,
              core_en_key_exps, core_key_valid, core_bdi_valid}, 132'd0);
        check("reset_data", {4'h0, m_data | core_key | core_bdi}, 132'd0);
        rst = 1'b0;

        // ECB vector table: SM4 reference pairs plus stand-in vectors under random keys.
        vecs[0] = '{1'b1, K0, P0, C0};
        vecs[1] = '{1'b0, K0, C0, P0};
        for (int i = 2; i < 6; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rd = {$urandom, $urandom, $urandom, $urandom};
            vecs[i] = '{(i % 2) == 0, rk, rd, core_f((i % 2) == 0, rk, rd)};
        end
        for (int i = 0; i < 6; i++) begin
            load_key(vecs[i].enc, 1'b0, vecs[i].key);
            send_block(vecs[i].din, vecs[i].dout, 1'b1);
            drain("vec_drain");
        end

`ifdef SM4_CBC_EN
        load_key(1'b1, 1'b1, K0);
        load_iv('0);
        send_block(P0, C0, 1'b1);
        drain("cbc_enc_b1");
        send_block(P1, C0, 1'b1);
        drain("cbc_enc_b2");
        check("cbc_enc_bdi2", {4'h0, last_bdi}, {4'h0, P0});

        load_key(1'b0, 1'b1, K0);
        load_iv('0);
        send_block(C0, P0, 1'b1);
        drain("cbc_dec_b1");
        send_block(C0, P1, 1'b1);
        drain("cbc_dec_b2");

        // IV loaded in the same cycle as the block: the block must use the new IV.
        load_key(1'b1, 1'b1, K0);
        iv = {$urandom, $urandom, $urandom, $urandom};
        x  = {$urandom, $urandom, $urandom, $urandom};
        wait_ready("iv_same_cycle_ready");
        iv_in = iv; iv_load = 1'b1; s_data = x; s_valid = 1'b1;
        prev = core_f(1'b1, K0, x ^ iv);
        exp_q.push_back(prev);
        @(posedge clk); #1;
        iv_load = 1'b0; s_valid = 1'b0;
        drain("cbc_iv_same_cycle");
        y = {$urandom, $urandom, $urandom, $urandom};
        send_block(y, core_f(1'b1, K0, y ^ prev), 1'b1);
        drain("cbc_chain_follow");
`else
        // Without chaining support, cbc_mode and the IV have no effect.
        load_key(1'b1, 1'b1, K0);
        load_iv({$urandom, $urandom, $urandom, $urandom});
        send_block(P0, C0, 1'b1);
        drain("ecb_only_b1");
        send_block(P1, core_f(1'b1, K0, P1), 1'b1);
        drain("ecb_only_b2");
        check("ecb_only_bdi2", {4'h0, last_bdi}, {4'h0, P1});
`endif

        // Backpressure: output held while m_ready is low, no new block accepted.
        load_key(1'b1, 1'b0, K0);
        m_ready = 1'b0;
        send_block(P0, C0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (!(m_valid === 1'b1 && s_ready === 1'b0 && m_data === C0)) bad++;
            @(negedge clk);
        end
        check("bp_hold_cycles_bad", 132'(bad), 132'd0);
        check("bp_m_data", {4'h0, m_data}, {4'h0, C0});
        @(posedge clk); #1;
        m_ready = 1'b1;
        drain("bp_release");

        // key_load beats s_valid in READY.
        wait_ready("prio_ready");
        key_in = K0; encdec_in = 1'b1; cbc_mode = 1'b0; key_load = 1'b1;
        s_data = P0; s_valid = 1'b1;
        #1;
        check("prio_s_ready", {131'h0, s_ready}, 132'd0);
        @(posedge clk); #1;
        key_load = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check("prio_keyexp", {130'h0, core_en_key_exps, busy}, {130'h0, 2'b11});
        wait_ready("prio_keyexp_done");
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (m_valid || core_bdi_valid) bad++;
            @(negedge clk);
        end
        check("prio_no_block", 132'(bad), 132'd0);

        // Watchdog: core never answers.
        core_hang = 1'b1;
        send_block(P0, '0, 1'b0);
        wait_bdi_valid("wd_issue");
        n = 0;
        while (!err && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("wd_cycles_in_window", {131'h0, (n >= 1023 && n <= 1025)}, 132'd1);
        check("wd_idle", {127'h0, err, busy, core_en_sm4, s_ready, core_bdi_valid},
              {127'h0, 5'b10000});
        core_hang = 1'b0;
        load_key(1'b1, 1'b0, K0);
        check("err_cleared", {131'h0, err}, 132'd0);

        // Asynchronous reset in WAIT.
        core_hang = 1'b1;
        send_block(P0, '0, 1'b0);
        wait_bdi_valid("rst_wait_issue");
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_ctrl", {123'h0, s_ready, m_valid, busy, err, core_en_sm4, core_encdec,
              core_en_key_exps, core_key_valid, core_bdi_valid}, 132'd0);
        check("rst_async_data", {4'h0, m_data | core_key | core_bdi}, 132'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        core_hang = 1'b0;
        load_key(1'b1, 1'b0, K0);
        send_block(P0, C0, 1'b1);
        drain("post_reset_block");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
